// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// One request strobe per fetch; the response strobe may come one or more cycles later.
interface fetch_pc_unit_if #(
  parameter int DATA_W = 16
);
  logic              imem_req;
  logic [DATA_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight,
// fills the IF/ID register and handles branch/jump redirects and flushes.
module fetch_pc_unit #(
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branchSignal,
  input  logic [DATA_W-1:0] offset,
  input  logic [DATA_W-1:0] branch_pc,
  input  logic              jump,
  input  logic [DATA_W-1:0] jump_target,
  fetch_pc_unit_if.master   imem,
  output logic [DATA_W-1:0] if_instr,
  output logic [DATA_W-1:0] if_pc,
  output logic              if_valid,
  output logic [DATA_W-1:0] pc
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              req_q, req_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] ifpc_q, ifpc_d;
  logic              ifv_q, ifv_d;
  logic              drop_q, drop_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic              redirect;
  logic [DATA_W-1:0] target;
  logic [DATA_W-1:0] pc_inc;

  // Branch beats jump when both are raised in the same cycle.
  assign redirect = branchSignal | jump;
  assign target   = branchSignal ? (branch_pc + offset) : jump_target;
  assign pc_inc   = pc_q + DATA_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      instr_q <= NOP_INSTR;
      ifpc_q  <= '0;
      ifv_q   <= 1'b0;
      drop_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      ifv_q   <= ifv_d;
      drop_q  <= drop_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = 1'b0;
    addr_d  = addr_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    ifv_d   = ifv_q;
    drop_d  = drop_q;
    hold_d  = hold_q;

    // Bubble when decode is free to advance; flush on redirect regardless of stall.
    if (!stall || redirect) begin
      ifv_d   = 1'b0;
      instr_d = NOP_INSTR;
    end

    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          pc_d = target;
        end else begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect) begin
          pc_d = target;
          // Response still in flight: remember to throw it away when it lands.
          drop_d = ~imem.imem_valid;
          if (imem.imem_valid) state_d = S_FETCH;
        end else if (imem.imem_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_FETCH;
          end else if (!stall) begin
            instr_d = imem.imem_rdata;
            ifpc_d  = pc_q;
            ifv_d   = 1'b1;
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end else begin
            hold_d  = imem.imem_rdata;
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = S_FETCH;
        end else if (!stall) begin
          instr_d = hold_q;
          ifpc_d  = pc_q;
          ifv_d   = 1'b1;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end

      default: state_d = S_FETCH;
    endcase
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign if_instr       = instr_q;
  assign if_pc          = ifpc_q;
  assign if_valid       = ifv_q;
  assign pc             = pc_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a small latency-programmable imem model
// answers requests, and each step checks the registered outputs by hand-computed values.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branchSignal;
  logic [15:0] offset;
  logic [15:0] branch_pc;
  logic        jump;
  logic [15:0] jump_target;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_valid;
  logic [15:0] pc;

  fetch_pc_unit_if #(.DATA_W(16)) imem ();

  fetch_pc_unit #(
    .DATA_W   (16),
    .RESET_PC (16'h0000),
    .NOP_INSTR(16'h0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .branchSignal(branchSignal),
    .offset      (offset),
    .branch_pc   (branch_pc),
    .jump        (jump),
    .jump_target (jump_target),
    .imem        (imem),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_valid    (if_valid),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;

  // imem model state
  logic        pend;
  int          cnt;
  int          lat;
  logic [15:0] paddr;
  logic        use_ovr;
  logic [15:0] ovr;

  // Advance one clock, then let the memory model react to the new outputs.
  task automatic tick();
    @(posedge clk);
    #1;
    if (imem.imem_valid) pend = 1'b0;
    if (imem.imem_req === 1'b1) begin
      pend  = 1'b1;
      paddr = imem.imem_addr;
      cnt   = lat;
    end else if (pend && cnt > 0) begin
      cnt = cnt - 1;
    end
    imem.imem_valid = pend && (cnt == 0);
    imem.imem_rdata = use_ovr ? ovr : (16'h1000 + paddr);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branchSignal = 1'b0; offset = '0; branch_pc = '0;
    jump = 1'b0; jump_target = '0;
    imem.imem_valid = 1'b0; imem.imem_rdata = '0;
    pend = 1'b0; cnt = 0; lat = 0; paddr = '0; use_ovr = 1'b0; ovr = '0;

    tick(); tick();
    chk("rst_pc", pc, 16'h0000);
    chk("rst_req", 16'(imem.imem_req), 16'h0);
    chk("rst_addr", imem.imem_addr, 16'h0000);
    chk("rst_ifv", 16'(if_valid), 16'h0);
    chk("rst_instr", if_instr, 16'h0000);
    chk("rst_ifpc", if_pc, 16'h0000);
    reset = 1'b0;

    // zero-wait sequential fetch: one instruction every second cycle
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("seq_req", 16'(imem.imem_req), 16'h1);
      chk("seq_addr", imem.imem_addr, 16'(i));
      chk("seq_ifv_lo", 16'(if_valid), 16'h0);
      tick();
      chk("seq_ifv_hi", 16'(if_valid), 16'h1);
      chk("seq_instr", if_instr, 16'h1000 + 16'(i));
      chk("seq_ifpc", if_pc, 16'(i));
      chk("seq_pc", pc, 16'(i + 1));
      chk("seq_req_lo", 16'(imem.imem_req), 16'h0);
    end

    // backward branch with wrap, taken in the cycle the response lands
    tick();
    chk("br_pc_wait", pc, 16'h0005);
    branchSignal = 1'b1; branch_pc = 16'h0003; offset = 16'hFFFC;
    tick();
    chk("br_pc", pc, 16'hFFFF);
    chk("br_ifv", 16'(if_valid), 16'h0);
    branchSignal = 1'b0; use_ovr = 1'b1; ovr = 16'hABCD;
    tick();
    chk("br_req", 16'(imem.imem_req), 16'h1);
    chk("br_addr", imem.imem_addr, 16'hFFFF);
    tick();
    chk("br_instr", if_instr, 16'hABCD);
    chk("br_ifpc", if_pc, 16'hFFFF);
    chk("br_ifv_hi", 16'(if_valid), 16'h1);
    chk("br_pc_wrap", pc, 16'h0000);

    // jump while a 3-cycle response is outstanding
    use_ovr = 1'b0; lat = 3;
    tick();
    chk("jmp_req0", imem.imem_addr, 16'h0000);
    jump = 1'b1; jump_target = 16'h0040;
    tick();
    chk("jmp_pc", pc, 16'h0040);
    chk("jmp_ifv", 16'(if_valid), 16'h0);
    jump = 1'b0;
    tick(); tick();
    chk("jmp_stale_req", 16'(imem.imem_req), 16'h0);
    chk("jmp_stale_ifv", 16'(if_valid), 16'h0);
    tick();
    chk("jmp_drop_ifv", 16'(if_valid), 16'h0);
    chk("jmp_drop_pc", pc, 16'h0040);
    chk("jmp_drop_req", 16'(imem.imem_req), 16'h0);
    tick();
    chk("jmp_new_req", 16'(imem.imem_req), 16'h1);
    chk("jmp_new_addr", imem.imem_addr, 16'h0040);
    for (int i = 0; i < 4; i++) tick();
    chk("jmp_instr", if_instr, 16'h1040);
    chk("jmp_ifpc", if_pc, 16'h0040);
    chk("jmp_ifv", 16'(if_valid), 16'h1);
    chk("jmp_pc_inc", pc, 16'h0041);

    // stall holds IF/ID while the response parks in the hold buffer
    lat = 0; use_ovr = 1'b1; ovr = 16'h2222; stall = 1'b1;
    tick();
    chk("stl_req_addr", imem.imem_addr, 16'h0041);
    chk("stl_ifv0", 16'(if_valid), 16'h1);
    chk("stl_instr0", if_instr, 16'h1040);
    tick();
    chk("stl_ifv1", 16'(if_valid), 16'h1);
    chk("stl_instr1", if_instr, 16'h1040);
    chk("stl_ifpc1", if_pc, 16'h0040);
    chk("stl_pc1", pc, 16'h0041);
    tick();
    chk("stl_instr2", if_instr, 16'h1040);
    chk("stl_req2", 16'(imem.imem_req), 16'h0);
    stall = 1'b0;
    tick();
    chk("stl_rel_instr", if_instr, 16'h2222);
    chk("stl_rel_ifpc", if_pc, 16'h0041);
    chk("stl_rel_ifv", 16'(if_valid), 16'h1);
    chk("stl_rel_pc", pc, 16'h0042);

    // stall and branch together: the redirect wins and flushes IF/ID
    stall = 1'b1; branchSignal = 1'b1; branch_pc = 16'h0100; offset = 16'h0010;
    tick();
    chk("sb_pc", pc, 16'h0110);
    chk("sb_ifv", 16'(if_valid), 16'h0);
    chk("sb_instr", if_instr, 16'h0000);
    chk("sb_req", 16'(imem.imem_req), 16'h0);
    stall = 1'b0; branchSignal = 1'b0; use_ovr = 1'b0; lat = 3;
    tick();
    chk("sb_new_addr", imem.imem_addr, 16'h0110);

    // reset mid-WAIT, then a late response arriving in FETCH
    reset = 1'b1;
    tick();
    chk("rw_pc", pc, 16'h0000);
    chk("rw_req", 16'(imem.imem_req), 16'h0);
    chk("rw_ifv", 16'(if_valid), 16'h0);
    pend = 1'b0; lat = 1;
    reset = 1'b0;
    imem.imem_valid = 1'b1; imem.imem_rdata = 16'hDEAD;
    tick();
    chk("rw_req1", 16'(imem.imem_req), 16'h1);
    chk("rw_addr1", imem.imem_addr, 16'h0000);
    chk("rw_ifv1", 16'(if_valid), 16'h0);
    chk("rw_pc1", pc, 16'h0000);
    tick();
    chk("rw_ifv2", 16'(if_valid), 16'h0);
    tick();
    chk("rw_instr", if_instr, 16'h1000);
    chk("rw_ifpc", if_pc, 16'h0000);
    chk("rw_ifv3", 16'(if_valid), 16'h1);
    chk("rw_pc3", pc, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
